// File: rtl/jtkcpu_io_ctrl.sv
// Main-CPU I/O page controller for KCPU boards: bank/latch/video registers, sound IRQ hold,
// watchdog (built only when JTKIO_WDOG_EN is defined) and a registered cabinet/DIP read mux.
module jtkcpu_io_ctrl #(
   parameter int BANK_W     = 4,
   parameter int VBANK_W    = 2,
   parameter int SNDIRQ_LEN = 8,
   parameter int WDOG_MAX   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cpu_cen,
   input  logic               io_cs,
   input  logic [4:0]         addr,
   input  logic               cpu_we,
   input  logic [7:0]         cpu_dout,
   output logic [7:0]         port_dout,
   output logic [BANK_W-1:0]  bank,
   output logic               work,
   output logic [1:0]         coin_lock,
   output logic [7:0]         snd_latch,
   output logic               snd_irq,
   input  logic               snd_ack,
   output logic [VBANK_W-1:0] video_bank,
   output logic               prio,
   input  logic               vblank,
   output logic               wdog_rst,
   input  logic [1:0]         start_button,
   input  logic [1:0]         coin_input,
   input  logic               service,
   input  logic [6:0]         joystick1,
   input  logic [6:0]         joystick2,
   input  logic [7:0]         dipsw_a,
   input  logic [7:0]         dipsw_b,
   input  logic [3:0]         dipsw_c
);

   localparam logic [7:0] SND_LEN = 8'(SNDIRQ_LEN);

   typedef enum logic [2:0] {
      SLOT_BANK  = 3'd0,
      SLOT_LATCH = 3'd1,
      SLOT_SIRQ  = 3'd2,
      SLOT_WDOG  = 3'd3,
      SLOT_CAB   = 3'd4,
      SLOT_DIP   = 3'd5,
      SLOT_VIDEO = 3'd6,
      SLOT_NONE  = 3'd7
   } slot_e;

   slot_e slot;
   logic  acc, wr, rd;

   assign slot = slot_e'(addr[4:2]);
   assign acc  = io_cs & cpu_cen;
   assign wr   = acc & cpu_we;
   assign rd   = acc & ~cpu_we;

   logic [BANK_W-1:0]  bank_q, bank_d;
   logic               work_q, work_d;
   logic [1:0]         coin_q, coin_d;
   logic [7:0]         latch_q, latch_d;
   logic [VBANK_W-1:0] vb_q, vb_d;
   logic               prio_q, prio_d;
   logic [7:0]         dout_q, dout_d;
   logic [7:0]         rd_mux;
   logic [7:0]         vid_ext;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      bank_d  = bank_q;
      work_d  = work_q;
      coin_d  = coin_q;
      latch_d = latch_q;
      vb_d    = vb_q;
      prio_d  = prio_q;
      dout_d  = dout_q;
      if (wr) begin
         case (slot)
            SLOT_BANK: begin
               work_d = cpu_dout[5];
               coin_d = cpu_dout[7:6];
               bank_d = cpu_dout[BANK_W-1:0];
            end
            SLOT_LATCH: latch_d = cpu_dout;
            SLOT_VIDEO: {prio_d, vb_d} = cpu_dout[VBANK_W:0];
            default: ;
         endcase
      end

      // Video readback uses the post-write value so a write is visible on the same access
      vid_ext = '0;
      vid_ext[VBANK_W:0] = {prio_d, vb_d};

      case (slot)
         SLOT_CAB: begin
            case (addr[1:0])
               2'd0:    rd_mux = {3'b111, start_button, service, coin_input};
               2'd1:    rd_mux = {2'b11, joystick1[5:0]};
               2'd2:    rd_mux = {2'b11, joystick2[5:0]};
               default: rd_mux = {2'b11, joystick2[6], joystick1[6], dipsw_c};
            endcase
         end
         SLOT_DIP:   rd_mux = addr[0] ? dipsw_b : dipsw_a;
         SLOT_VIDEO: rd_mux = vid_ext;
         default:    rd_mux = 8'hFF;
      endcase

      if (rd || (wr && slot == SLOT_VIDEO)) dout_d = rd_mux;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_q  <= '0;
         work_q  <= 1'b0;
         coin_q  <= 2'b00;
         latch_q <= 8'h00;
         vb_q    <= '0;
         prio_q  <= 1'b0;
         dout_q  <= 8'hFF;
      end else begin
         bank_q  <= bank_d;
         work_q  <= work_d;
         coin_q  <= coin_d;
         latch_q <= latch_d;
         vb_q    <= vb_d;
         prio_q  <= prio_d;
         dout_q  <= dout_d;
      end
   end

   logic       irq_q, irq_d;
   logic [7:0] irq_cnt_q, irq_cnt_d;

   // Priority: retrigger write > acknowledge > cen-driven countdown
   always_comb begin
      irq_d     = irq_q;
      irq_cnt_d = irq_cnt_q;
      if (irq_q && cpu_cen) begin
         irq_cnt_d = irq_cnt_q - 8'd1;
         if (irq_cnt_q <= 8'd1) irq_d = 1'b0;
      end
      if (snd_ack) begin
         irq_d     = 1'b0;
         irq_cnt_d = 8'd0;
      end
      if (wr && slot == SLOT_SIRQ) begin
         irq_d     = 1'b1;
         irq_cnt_d = SND_LEN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_q     <= 1'b0;
         irq_cnt_q <= 8'd0;
      end else begin
         irq_q     <= irq_d;
         irq_cnt_q <= irq_cnt_d;
      end
   end

`ifdef JTKIO_WDOG_EN
   localparam logic [7:0] WDOG_LAST = 8'(WDOG_MAX - 1);

   logic       vb_dly_q;
   logic [7:0] wcnt_q, wcnt_d;
   logic       wdog_q, wdog_d;
   logic       vb_rise, kick;

   assign vb_rise = vblank & ~vb_dly_q;
   assign kick    = acc && slot == SLOT_WDOG;

   always_comb begin
      wcnt_d = wcnt_q;
      wdog_d = 1'b0;
      if (kick) begin
         wcnt_d = 8'd0;
      end else if (vb_rise) begin
         if (wcnt_q >= WDOG_LAST) begin
            wcnt_d = 8'd0;
            wdog_d = 1'b1;
         end else begin
            wcnt_d = wcnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vb_dly_q <= 1'b0;
         wcnt_q   <= 8'd0;
         wdog_q   <= 1'b0;
      end else begin
         vb_dly_q <= vblank;
         wcnt_q   <= wcnt_d;
         wdog_q   <= wdog_d;
      end
   end

   assign wdog_rst = wdog_q;
`else
   logic unused_vblank;
   assign unused_vblank = vblank;
   assign wdog_rst      = 1'b0;
`endif

   assign port_dout  = dout_q;
   assign bank       = bank_q;
   assign work       = work_q;
   assign coin_lock  = coin_q;
   assign snd_latch  = latch_q;
   assign snd_irq    = irq_q;
   assign video_bank = vb_q;
   assign prio       = prio_q;

endmodule

// File: tb/tb_jtkcpu_io_ctrl.sv
// Scoreboard bench for jtkcpu_io_ctrl: a behavioural model pushes expected register snapshots,
// a monitor pops and compares them; snd_irq and wdog_rst are compared every clock.
module tb_jtkcpu_io_ctrl;

   localparam int BANK_W     = 4;
   localparam int VBANK_W    = 2;
   localparam int SNDIRQ_LEN = 8;
   localparam int WDOG_MAX   = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       cpu_cen, io_cs, cpu_we, snd_ack, vblank, service;
   logic [4:0] addr;
   logic [7:0] cpu_dout, dipsw_a, dipsw_b;
   logic [1:0] start_button, coin_input;
   logic [6:0] joystick1, joystick2;
   logic [3:0] dipsw_c;

   logic [7:0]         port_dout, snd_latch;
   logic [BANK_W-1:0]  bank;
   logic               work, snd_irq, prio, wdog_rst;
   logic [1:0]         coin_lock;
   logic [VBANK_W-1:0] video_bank;

   jtkcpu_io_ctrl #(
      .BANK_W(BANK_W), .VBANK_W(VBANK_W), .SNDIRQ_LEN(SNDIRQ_LEN), .WDOG_MAX(WDOG_MAX)
   ) dut (
      .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .io_cs(io_cs), .addr(addr), .cpu_we(cpu_we),
      .cpu_dout(cpu_dout), .port_dout(port_dout), .bank(bank), .work(work),
      .coin_lock(coin_lock), .snd_latch(snd_latch), .snd_irq(snd_irq), .snd_ack(snd_ack),
      .video_bank(video_bank), .prio(prio), .vblank(vblank), .wdog_rst(wdog_rst),
      .start_button(start_button), .coin_input(coin_input), .service(service),
      .joystick1(joystick1), .joystick2(joystick2), .dipsw_a(dipsw_a), .dipsw_b(dipsw_b),
      .dipsw_c(dipsw_c)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [7:0]         dout;
      bit                 chk_dout;
      logic [BANK_W-1:0]  bank;
      logic               work;
      logic [1:0]         coin;
      logic [7:0]         latch;
      logic [VBANK_W-1:0] vb;
      logic               prio;
   } snap_t;

   snap_t sb_q[$];

   // Reference model state
   logic [BANK_W-1:0]  m_bank;
   logic               m_work, m_prio;
   logic [1:0]         m_coin;
   logic [7:0]         m_latch, m_dout;
   logic [VBANK_W-1:0] m_vb;
   int  cen_cnt, trig_cen, frames;
   bit  irq_on, exp_irq, exp_wdog, prev_vb;

   function automatic logic [7:0] read_value(input logic [2:0] slot, input logic [1:0] sub);
      case (slot)
         3'd4: case (sub)
            2'd0:    return {3'b111, start_button, service, coin_input};
            2'd1:    return {2'b11, joystick1[5:0]};
            2'd2:    return {2'b11, joystick2[5:0]};
            default: return {2'b11, joystick2[6], joystick1[6], dipsw_c};
         endcase
         3'd5:    return sub[0] ? dipsw_b : dipsw_a;
         3'd6:    return {5'd0, m_prio, m_vb};
         default: return 8'hFF;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_bank = '0; m_work = 0; m_coin = 0; m_latch = 0; m_vb = '0; m_prio = 0;
         m_dout = 8'hFF; irq_on = 0; exp_irq = 0; exp_wdog = 0; prev_vb = 0;
         cen_cnt = 0; trig_cen = 0; frames = 0;
         sb_q.delete();
      end else begin
         bit         acc, rise;
         logic [2:0] slot;
         snap_t      s;
         acc  = io_cs && cpu_cen;
         slot = addr[4:2];
         if (cpu_cen) cen_cnt++;
         if (acc && cpu_we && slot == 3'd2) begin
            irq_on   = 1;
            trig_cen = cen_cnt;
         end else if (snd_ack) begin
            irq_on = 0;
         end
         exp_irq = irq_on && (cen_cnt - trig_cen < SNDIRQ_LEN);

         rise     = vblank && !prev_vb;
         prev_vb  = vblank;
         exp_wdog = 0;
`ifdef JTKIO_WDOG_EN
         if (acc && slot == 3'd3) frames = 0;
         else if (rise) begin
            frames++;
            if (frames == WDOG_MAX) begin
               exp_wdog = 1;
               frames   = 0;
            end
         end
`else
         if (rise) frames++;
`endif

         if (acc) begin
            if (cpu_we) begin
               case (slot)
                  3'd0: begin m_bank = cpu_dout[BANK_W-1:0]; m_work = cpu_dout[5]; m_coin = cpu_dout[7:6]; end
                  3'd1: m_latch = cpu_dout;
                  3'd6: begin m_vb = cpu_dout[VBANK_W-1:0]; m_prio = cpu_dout[VBANK_W]; end
                  default: ;
               endcase
            end else begin
               m_dout = read_value(slot, addr[1:0]);
            end
            s.dout = m_dout; s.chk_dout = !cpu_we; s.bank = m_bank; s.work = m_work;
            s.coin = m_coin; s.latch = m_latch; s.vb = m_vb; s.prio = m_prio;
            sb_q.push_back(s);
         end
      end
   end

   int wdog_pulses = 0;

   always @(posedge clk) begin
      #1;
      if (!rst) begin
         check("snd_irq", snd_irq, exp_irq);
         check("wdog_rst", wdog_rst, exp_wdog);
         if (wdog_rst) wdog_pulses++;
         if (sb_q.size() > 0) begin
            snap_t s;
            s = sb_q.pop_front();
            if (s.chk_dout) check("port_dout", port_dout, s.dout);
            check("bank", bank, s.bank);
            check("work", work, s.work);
            check("coin_lock", coin_lock, s.coin);
            check("snd_latch", snd_latch, s.latch);
            check("video_bank", video_bank, s.vb);
            check("prio", prio, s.prio);
         end
      end
   end

   task automatic access(input bit we, input logic [2:0] slot, input logic [1:0] sub,
                         input logic [7:0] d, input bit ack);
      @(negedge clk);
      io_cs = 1; cpu_cen = 1; cpu_we = we; addr = {slot, sub}; cpu_dout = d; snd_ack = ack;
      @(negedge clk);
      io_cs = 0; cpu_cen = 0; snd_ack = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         io_cs = 0; cpu_cen = 1'($urandom % 2);
      end
   endtask

   task automatic frame();
      @(negedge clk); vblank = 1; io_cs = 0;
      repeat (3) @(negedge clk);
      vblank = 0;
      repeat (6) @(negedge clk);
   endtask

   task automatic check_reset_outputs();
      check("rst port_dout", port_dout, 8'hFF);
      check("rst bank", bank, 0);
      check("rst work", work, 0);
      check("rst coin_lock", coin_lock, 0);
      check("rst snd_latch", snd_latch, 0);
      check("rst snd_irq", snd_irq, 0);
      check("rst video_bank", video_bank, 0);
      check("rst prio", prio, 0);
      check("rst wdog_rst", wdog_rst, 0);
   endtask

   initial begin
      int p0;
      rst = 1; cpu_cen = 0; io_cs = 0; cpu_we = 0; addr = 0; cpu_dout = 0; snd_ack = 0;
      vblank = 0; service = 1; start_button = 2'b01; coin_input = 2'b10;
      joystick1 = 7'h55; joystick2 = 7'h2A; dipsw_a = 8'hA5; dipsw_b = 8'h3C; dipsw_c = 4'h9;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst = 0;

      // Bank/work/coin register and cabinet read
      access(1, 3'd0, 2'd0, 8'h2B, 0);
      access(0, 3'd4, 2'd0, 8'h00, 0);
      for (int s = 1; s < 4; s++) access(0, 3'd4, 2'(s), 8'h00, 0);

      // Sound latch, IRQ hold, retrigger at the fifth tick
      access(1, 3'd1, 2'd0, 8'h5A, 0);
      access(1, 3'd2, 2'd0, 8'h00, 0);
      idle(24);
      access(1, 3'd2, 2'd0, 8'h00, 0);
      repeat (4) begin @(negedge clk); cpu_cen = 1; @(negedge clk); cpu_cen = 0; end
      access(1, 3'd2, 2'd0, 8'h00, 0);
      idle(30);

      // Acknowledge, then acknowledge colliding with a retrigger
      access(1, 3'd2, 2'd0, 8'h00, 0);
      repeat (2) begin @(negedge clk); cpu_cen = 1; end
      @(negedge clk); cpu_cen = 0; snd_ack = 1;
      @(negedge clk); snd_ack = 0;
      access(1, 3'd2, 2'd0, 8'h00, 1);
      idle(20);

      // Video control and DIP reads, plus write-only slot reads
      access(1, 3'd6, 2'd0, 8'h07, 0);
      access(0, 3'd6, 2'd0, 8'h00, 0);
      access(0, 3'd5, 2'd1, 8'h00, 0);
      access(0, 3'd5, 2'd0, 8'h00, 0);
      for (int s = 0; s < 4; s++) access(0, 3'(s), 2'd0, 8'h00, 0);
      access(0, 3'd7, 2'd2, 8'h00, 0);

      // Watchdog: unkicked frames, then frames kicked every third
      access(0, 3'd3, 2'd0, 8'h00, 0);
      p0 = wdog_pulses;
      repeat (8) frame();
`ifdef JTKIO_WDOG_EN
      check("wdog pulses unkicked", wdog_pulses - p0, 8 / WDOG_MAX);
`else
      repeat (92) frame();
      check("wdog pulses disabled", wdog_pulses - p0, 0);
`endif
      p0 = wdog_pulses;
      for (int f = 0; f < 12; f++) begin
         if (f % 3 == 0) access(1, 3'd3, 2'd0, 8'h00, 0);
         frame();
      end
      check("wdog pulses kicked", wdog_pulses - p0, 0);

      // Async reset with IRQ pending and three frames counted
      access(1, 3'd2, 2'd0, 8'h00, 0);
      access(0, 3'd3, 2'd0, 8'h00, 0);
      repeat (3) frame();
      @(negedge clk); #2 rst = 1; #1;
      check_reset_outputs();
      @(negedge clk); @(negedge clk); rst = 0;
      p0 = wdog_pulses;
      repeat (3) frame();
      check("wdog pulses after reset", wdog_pulses - p0, 0);

      // Randomised traffic
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         cpu_cen  = 1'($urandom % 2);
         io_cs    = ($urandom % 4) == 0;
         cpu_we   = 1'($urandom % 2);
         addr     = 5'($urandom);
         cpu_dout = 8'($urandom);
         snd_ack  = ($urandom % 16) == 0;
         vblank   = (i % 14) < 3;
         start_button = 2'($urandom); coin_input = 2'($urandom); service = 1'($urandom);
         joystick1 = 7'($urandom); joystick2 = 7'($urandom);
         dipsw_a = 8'($urandom); dipsw_b = 8'($urandom); dipsw_c = 4'($urandom);
      end
      @(negedge clk); io_cs = 0; cpu_cen = 0; snd_ack = 0;
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
